// File: rtl/flag_unit_pkg.sv
// Shared definitions for the condition-flag unit.
// Contents:
//   - opcode constants for the EX-stage opcode field
//   - flag bit positions inside the 3-bit {V,N,Z} bus
//   - the flag-state enum
//   - op_mask(): which flags an opcode is allowed to update
package flag_unit_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
    localparam logic [OP_W-1:0] OP_XOR = 4'b0010;
    localparam logic [OP_W-1:0] OP_AND = 4'b0011;
    localparam logic [OP_W-1:0] OP_SLL = 4'b0100;
    localparam logic [OP_W-1:0] OP_SRA = 4'b0101;
    localparam logic [OP_W-1:0] OP_ROR = 4'b0110;
    localparam logic [OP_W-1:0] OP_HLT = 4'b1111;

    localparam int FLG_V = 2;
    localparam int FLG_N = 1;
    localparam int FLG_Z = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        HALTED = 2'd2
    } flag_state_e;

    // Arithmetic ops own all three flags.
    // Logic/shift ops only define Z.
    // Everything else leaves the flags alone.
    function automatic logic [2:0] op_mask(input logic [OP_W-1:0] op);
        logic [2:0] m;
        m = 3'b000;
        case (op)
            OP_ADD, OP_SUB:         m = 3'b111;
            OP_XOR, OP_SLL,
            OP_SRA, OP_ROR:         m = 3'b001;
            default:                m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/flag_unit_compute.sv
// Combinational flag derivation from an EX-stage ALU result.
// Ports:
//   op_i     - EX opcode
//   result_i - ALU result
//   ovfl_i   - adder signed overflow
//   flags_o  - raw {V,N,Z} before masking
//   mask_o   - flags this opcode is allowed to update
module flag_compute
    import flag_unit_pkg::*;
#(
    parameter int DW  = 16,
    parameter int OPW = 4
) (
    input  logic [OPW-1:0] op_i,
    input  logic [DW-1:0]  result_i,
    input  logic           ovfl_i,
    output logic [2:0]     flags_o,
    output logic [2:0]     mask_o
);

    // V is passed through unconditionally.
    // The mask keeps it from landing for non-arithmetic ops.
    assign flags_o[FLG_V] = ovfl_i;
    assign flags_o[FLG_N] = result_i[DW-1];
    assign flags_o[FLG_Z] = (result_i == '0);

    assign mask_o = op_mask(OP_W'(op_i));

endmodule

// File: rtl/flag_unit.sv
// Condition-flag producer for the branch/PC-select logic.
// An EX-stage flag setter is captured into a speculative pending entry.
// The pending entry commits to the architectural flags one cycle later,
// unless it is flushed.
// Ports:
//   ex_valid/ex_op/alu_result/alu_ovfl - EX-stage instruction and ALU outputs
//   stall - hold all state
//   flush - squash the pending entry
//   halt  - freeze the unit until reset
//   flags      - bypassed {V,N,Z}: pending bits override committed ones
//   arch_flags - committed {V,N,Z}
//   flag_wr    - high in the cycle whose closing edge commits
//   wr_count   - saturating commit counter
module flag_unit
    import flag_unit_pkg::*;
#(
    parameter int DW  = 16,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ex_valid,
    input  logic [OPW-1:0] ex_op,
    input  logic [DW-1:0]  alu_result,
    input  logic           alu_ovfl,
    input  logic           stall,
    input  logic           flush,
    input  logic           halt,
    output logic [2:0]     flags,
    output logic [2:0]     arch_flags,
    output logic           flag_wr,
    output logic [7:0]     wr_count
);

    flag_state_e state_q, state_d;
    logic [2:0]  arch_q, arch_d;
    logic [2:0]  pend_flags_q, pend_flags_d;
    logic [2:0]  pend_mask_q, pend_mask_d;
    logic [7:0]  wr_count_q, wr_count_d;

    logic [2:0]  cmp_flags, cmp_mask;
    logic        capture, commit, pend_valid;
    logic [2:0]  byp_sel;

    flag_compute #(.DW(DW), .OPW(OPW)) u_compute (
        .op_i     (ex_op),
        .result_i (alu_result),
        .ovfl_i   (alu_ovfl),
        .flags_o  (cmp_flags),
        .mask_o   (cmp_mask)
    );

    // State register
    // NOTE: sequential state uses non-blocking assignments,
    // so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            arch_q       <= 3'b000;
            pend_flags_q <= 3'b000;
            pend_mask_q  <= 3'b000;
            wr_count_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            arch_q       <= arch_d;
            pend_flags_q <= pend_flags_d;
            pend_mask_q  <= pend_mask_d;
            wr_count_q   <= wr_count_d;
        end
    end

    // Next-state logic
    // A halt wins over a capture on the same edge: nothing behind HLT may update flags.
    // PEND always drains this edge (commit or flush).
    // So a non-halting, non-capturing advance returns to IDLE.
    always_comb begin
        state_d = state_q;
        if (state_q != HALTED && !stall) begin
            if (halt)
                state_d = HALTED;
            else if (capture && cmp_mask != 3'b000)
                state_d = PEND;
            else
                state_d = IDLE;
        end
    end

    // FSM outputs
    // NOTE: every signal gets a default before the case statement.
    // No path leaves it unassigned, so no latch is inferred.
    always_comb begin
        capture    = 1'b0;
        commit     = 1'b0;
        pend_valid = 1'b0;
        case (state_q)
            IDLE: begin
                capture = ex_valid & ~stall & ~halt;
            end
            PEND: begin
                pend_valid = 1'b1;
                commit     = ~stall & ~flush;
                capture    = ex_valid & ~stall & ~halt;
            end
            HALTED: ;
            default: ;
        endcase
    end

    // Datapath
    // Commit and capture are independent.
    // Arch takes the old pending entry while pending reloads from EX,
    // giving in-order commits at one per cycle.
    always_comb begin
        arch_d       = arch_q;
        pend_flags_d = pend_flags_q;
        pend_mask_d  = pend_mask_q;
        wr_count_d   = wr_count_q;
        if (commit) begin
            arch_d = (arch_q & ~pend_mask_q) | (pend_flags_q & pend_mask_q);
            if (wr_count_q != 8'hFF)
                wr_count_d = wr_count_q + 8'd1;
        end
        if (capture) begin
            pend_flags_d = cmp_flags;
            pend_mask_d  = cmp_mask;
        end
    end

    // Bypass: a valid pending bit overrides the committed bit.
    assign byp_sel    = pend_mask_q & {3{pend_valid}};
    assign flags      = (byp_sel & pend_flags_q) | (~byp_sel & arch_q);
    assign arch_flags = arch_q;
    assign flag_wr    = commit;
    assign wr_count   = wr_count_q;

endmodule

// File: tb/tb_flag_unit.sv
module tb_flag_unit;
    import flag_unit_pkg::*;

    localparam int DW  = 16;
    localparam int OPW = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           ex_valid;
    logic [OPW-1:0] ex_op;
    logic [DW-1:0]  alu_result;
    logic           alu_ovfl;
    logic           stall;
    logic           flush;
    logic           halt;
    logic [2:0]     flags;
    logic [2:0]     arch_flags;
    logic           flag_wr;
    logic [7:0]     wr_count;

    always #5 clk = ~clk;

    flag_unit #(.DW(DW), .OPW(OPW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_valid   (ex_valid),
        .ex_op      (ex_op),
        .alu_result (alu_result),
        .alu_ovfl   (alu_ovfl),
        .stall      (stall),
        .flush      (flush),
        .halt       (halt),
        .flags      (flags),
        .arch_flags (arch_flags),
        .flag_wr    (flag_wr),
        .wr_count   (wr_count)
    );

    // Expected outputs are sampled at the negedge of the cycle the inputs are applied in.
    // flags/arch_flags/wr_count reflect earlier edges.
    // flag_wr reflects the commit on the coming edge.
    typedef struct {
        logic        valid;
        logic [3:0]  op;
        logic [15:0] res;
        logic        ovfl;
        logic        stall;
        logic        flush;
        logic        halt;
        logic [2:0]  e_flags;
        logic [2:0]  e_arch;
        logic        e_wr;
        logic [7:0]  e_cnt;
    } vec_t;

    typedef struct {
        logic [2:0] flags;
        logic [2:0] arch;
        logic       wr;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[$];
    vec_t halt_tbl[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [3:0] op, input logic [15:0] res,
                                input logic ov, input logic st, input logic fl, input logic ht,
                                input logic [2:0] ef, input logic [2:0] ea, input logic ew,
                                input logic [7:0] ec);
        vec_t r;
        r.valid = v;   r.op = op;     r.res = res;   r.ovfl = ov;
        r.stall = st;  r.flush = fl;  r.halt = ht;
        r.e_flags = ef; r.e_arch = ea; r.e_wr = ew;  r.e_cnt = ec;
        return r;
    endfunction

    // Drive one vector and push its expectation.
    // At the negedge, pop the expectation and compare.
    // Then advance past the posedge.
    task automatic run_vec(input string tag, input int idx, input vec_t v);
        exp_t e, got;
        ex_valid   = v.valid;
        ex_op      = v.op;
        alu_result = v.res;
        alu_ovfl   = v.ovfl;
        stall      = v.stall;
        flush      = v.flush;
        halt       = v.halt;
        e.flags = v.e_flags; e.arch = v.e_arch; e.wr = v.e_wr; e.cnt = v.e_cnt;
        sb_q.push_back(e);
        @(negedge clk);
        got = sb_q.pop_front();
        check($sformatf("%s[%0d].flags", tag, idx),      32'(flags),      32'(got.flags));
        check($sformatf("%s[%0d].arch_flags", tag, idx), 32'(arch_flags), 32'(got.arch));
        check($sformatf("%s[%0d].flag_wr", tag, idx),    32'(flag_wr),    32'(got.wr));
        check($sformatf("%s[%0d].wr_count", tag, idx),   32'(wr_count),   32'(got.cnt));
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid = 1'b0; ex_op = OP_AND; alu_result = '0; alu_ovfl = 1'b0;
        stall = 1'b0; flush = 1'b0; halt = 1'b0;
    endtask

    initial begin
        // Fields: valid op res ovfl stall flush halt | flags arch wr cnt
        // ADD 0x8000 with overflow: visible on flags at t+1, on arch at t+2.
        tbl.push_back(mk(1, OP_ADD, 16'h8000, 1, 0, 0, 0, 3'b000, 3'b000, 0, 8'd0));
        tbl.push_back(mk(0, OP_AND, 16'h0000, 0, 0, 0, 0, 3'b110, 3'b000, 1, 8'd0));
        tbl.push_back(mk(0, OP_AND, 16'h0000, 0, 0, 0, 0, 3'b110, 3'b110, 0, 8'd1));
        // XOR zero sets only Z (arch -> 111), a second XOR zero keeps 111,
        // and ROR 0x0001 clears Z alone (-> 110).
        tbl.push_back(mk(1, OP_XOR, 16'h0000, 0, 0, 0, 0, 3'b110, 3'b110, 0, 8'd1));
        tbl.push_back(mk(0, OP_AND, 16'h0000, 0, 0, 0, 0, 3'b111, 3'b110, 1, 8'd1));
        tbl.push_back(mk(1, OP_XOR, 16'h0000, 1, 0, 0, 0, 3'b111, 3'b111, 0, 8'd2));
        tbl.push_back(mk(0, OP_AND, 16'h0000, 0, 0, 0, 0, 3'b111, 3'b111, 1, 8'd2));
        tbl.push_back(mk(1, OP_ROR, 16'h0001, 0, 0, 0, 0, 3'b111, 3'b111, 0, 8'd3));
        tbl.push_back(mk(0, OP_AND, 16'h0000, 0, 0, 0, 0, 3'b110, 3'b111, 1, 8'd3));
        tbl.push_back(mk(0, OP_AND, 16'h0000, 0, 0, 0, 0, 3'b110, 3'b110, 0, 8'd4));
        // SUB 0 then ADD 5 back to back: consecutive commits 001 then 000.
        tbl.push_back(mk(1, OP_SUB, 16'h0000, 0, 0, 0, 0, 3'b110, 3'b110, 0, 8'd4));
        tbl.push_back(mk(1, OP_ADD, 16'h0005, 0, 0, 0, 0, 3'b001, 3'b110, 1, 8'd4));
        tbl.push_back(mk(0, OP_AND, 16'h0000, 0, 0, 0, 0, 3'b000, 3'b001, 1, 8'd5));
        tbl.push_back(mk(0, OP_AND, 16'h0000, 0, 0, 0, 0, 3'b000, 3'b000, 0, 8'd6));
        // Non-flag opcode: no pending entry, no commit.
        tbl.push_back(mk(1, OP_AND, 16'h0000, 1, 0, 0, 0, 3'b000, 3'b000, 0, 8'd6));
        tbl.push_back(mk(0, OP_AND, 16'h0000, 0, 0, 0, 0, 3'b000, 3'b000, 0, 8'd6));
        // ADD 0 then flush: no commit, and flags falls back to arch.
        tbl.push_back(mk(1, OP_ADD, 16'h0000, 0, 0, 0, 0, 3'b000, 3'b000, 0, 8'd6));
        tbl.push_back(mk(0, OP_AND, 16'h0000, 0, 0, 1, 0, 3'b001, 3'b000, 0, 8'd6));
        tbl.push_back(mk(0, OP_AND, 16'h0000, 0, 0, 0, 0, 3'b000, 3'b000, 0, 8'd6));
        // Flush while idle does nothing.
        tbl.push_back(mk(0, OP_AND, 16'h0000, 0, 0, 1, 0, 3'b000, 3'b000, 0, 8'd6));
        // ADD 0x8001, then a 3-cycle stall (one with a blocked EX capture),
        // then commit on the first free edge.
        tbl.push_back(mk(1, OP_ADD, 16'h8001, 0, 0, 0, 0, 3'b000, 3'b000, 0, 8'd6));
        tbl.push_back(mk(0, OP_AND, 16'h0000, 0, 1, 0, 0, 3'b010, 3'b000, 0, 8'd6));
        tbl.push_back(mk(0, OP_AND, 16'h0000, 0, 1, 0, 0, 3'b010, 3'b000, 0, 8'd6));
        tbl.push_back(mk(1, OP_ADD, 16'h0000, 1, 1, 0, 0, 3'b010, 3'b000, 0, 8'd6));
        tbl.push_back(mk(0, OP_AND, 16'h0000, 0, 0, 0, 0, 3'b010, 3'b000, 1, 8'd6));
        tbl.push_back(mk(0, OP_AND, 16'h0000, 0, 0, 0, 0, 3'b010, 3'b010, 0, 8'd7));

        // Halt with a pending SUB 0/ovfl: SUB commits (101).
        // Later captures, commits and flushes are ignored.
        halt_tbl.push_back(mk(1, OP_SUB, 16'h0000, 1, 0, 0, 0, 3'b110, 3'b110, 0, 8'd255));
        halt_tbl.push_back(mk(0, OP_AND, 16'h0000, 0, 0, 0, 1, 3'b101, 3'b110, 1, 8'd255));
        halt_tbl.push_back(mk(1, OP_ADD, 16'h8000, 0, 0, 0, 0, 3'b101, 3'b101, 0, 8'd255));
        halt_tbl.push_back(mk(0, OP_AND, 16'h0000, 0, 0, 0, 0, 3'b101, 3'b101, 0, 8'd255));
        halt_tbl.push_back(mk(1, OP_XOR, 16'h0000, 0, 0, 1, 0, 3'b101, 3'b101, 0, 8'd255));

        // Reset state
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("reset.flags",      32'(flags),      32'(3'b000));
        check("reset.arch_flags", 32'(arch_flags), 32'(3'b000));
        check("reset.flag_wr",    32'(flag_wr),    32'(1'b0));
        check("reset.wr_count",   32'(wr_count),   32'(8'd0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++)
            run_vec("vec", i, tbl[i]);

        // 260 back-to-back ADD setters drive the counter into saturation.
        // The last one (0x8103, ovfl=1) leaves arch = 110.
        for (int i = 0; i < 260; i++) begin
            ex_valid   = 1'b1;
            ex_op      = OP_ADD;
            alu_result = 16'h8000 | 16'(i);
            alu_ovfl   = i[0];
            stall = 1'b0; flush = 1'b0; halt = 1'b0;
            @(posedge clk);
            #1;
        end
        idle_inputs();
        @(negedge clk);
        check("sat.flag_wr_last", 32'(flag_wr), 32'(1'b1));
        @(posedge clk);
        #1;
        check("sat.wr_count",   32'(wr_count),   32'(8'd255));
        check("sat.arch_flags", 32'(arch_flags), 32'(3'b110));

        for (int i = 0; i < halt_tbl.size(); i++)
            run_vec("halt", i, halt_tbl[i]);

        // Reset clears the halted state.
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_halted.arch_flags", 32'(arch_flags), 32'(3'b000));
        check("rst_halted.flags",      32'(flags),      32'(3'b000));
        check("rst_halted.wr_count",   32'(wr_count),   32'(8'd0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Async reset with an entry pending: discarded, no commit.
        ex_valid = 1'b1; ex_op = OP_ADD; alu_result = 16'h8000; alu_ovfl = 1'b1;
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
        check("midrst.pre_flags", 32'(flags), 32'(3'b110));
        rst_n = 1'b0;
        #1;
        check("midrst.flags",      32'(flags),      32'(3'b000));
        check("midrst.arch_flags", 32'(arch_flags), 32'(3'b000));
        check("midrst.flag_wr",    32'(flag_wr),    32'(1'b0));
        check("midrst.wr_count",   32'(wr_count),   32'(8'd0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("postrst.arch_flags", 32'(arch_flags), 32'(3'b000));
        check("postrst.flags",      32'(flags),      32'(3'b000));
        check("postrst.wr_count",   32'(wr_count),   32'(8'd0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/flag_unit.md
Name: flag_unit

Overview:
- Producer side of the 3-bit condition-flag bus {V,N,Z} consumed by the branch/PC-select logic.
- Derives flags from EX-stage ALU results, per the ISA update rules, and holds them in a speculative pending stage.
- Commits pending flags to architectural flags one cycle later unless squashed.
- Presents a bypassed flag view so a branch directly behind a flag-setting instruction sees the correct values.

Parameters:
- DW, 16, ALU result width
- OPW, 4, opcode width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX stage holds a real instruction
- ex_op  in  OPW  EX-stage opcode
- alu_result  in  DW  EX-stage ALU output
- alu_ovfl  in  1  signed overflow from ALU adder (ADD/SUB)
- stall  in  1  pipeline hold; no state advances
- flush  in  1  squash the instruction that entered pending last cycle
- halt  in  1  HLT retired; freeze all flag state until reset
- flags  out  3  {V,N,Z} bypassed view for branch logic
- arch_flags  out  3  committed flags
- flag_wr  out  1  one-cycle pulse on any architectural flag commit
- wr_count  out  8  saturating count of commits (debug)

Behaviour:
- Encoding: bit2 = V, bit1 = N, bit0 = Z.
- Update mask by opcode:
  - ADD 0000, SUB 0001: V, N, Z
  - XOR 0010, SLL 0100, SRA 0101, ROR 0110: Z only
  - All other opcodes: none (mask 000)
- Z = (alu_result == 0). N = alu_result[DW-1]. V = alu_ovfl. V is meaningful only for ADD/SUB.
- Reset (async, rst_n low):
  - arch_flags = 000, pend_flags = 000, pend_mask = 000, pend_valid = 0
  - flags = 000, flag_wr = 0, wr_count = 0, halted = 0
- State machine, 3 states: IDLE (no pending), PEND (pending entry held), HALTED.
- Capture, on the edge when ex_valid & ~stall & ~halted:
  - pend_flags ← computed flags
  - pend_mask ← mask
  - pend_valid ← (mask != 0)
  - A capture with mask 000 leaves the unit in, or returns it to, IDLE at that edge.
- Commit, on the edge following capture (state PEND) when ~stall:
  - if ~flush: arch_flags[i] ← pend_flags[i] where pend_mask[i]; flag_wr = 1 for that cycle; wr_count increments, saturating at 255.
  - if flush: no commit, no flag_wr, pend_valid cleared.
- Simultaneous commit and new capture on the same edge:
  - Both occur: arch updates from the old pending entry; pending reloads from EX.
  - Back-to-back flag setters therefore commit in order, 1/cycle.
- Flush in IDLE is a no-op.
- Stall holds everything: pending, arch, state, counter. flag_wr = 0 while stalled.
- Bypass, combinational:
  - flags[i] = pend_flags[i] if pend_valid & pend_mask[i], else arch_flags[i]
  - Latency: a flag setter in EX at cycle t is visible on flags at t+1 and on arch_flags at t+2.
- Halt, sampled when ~stall:
  - Any pending entry commits normally on that edge, unless flush.
  - The unit then enters HALTED: no further captures, commits or counts.
  - Outputs hold until rst_n.
- Reset mid-operation: pending entries are discarded, with no commit.

Decomposition:
- Shared package holds:
  - opcode constants (OP_ADD … OP_HLT)
  - flag bit indices FLG_V = 2, FLG_N = 1, FLG_Z = 0
  - flag-state enum {IDLE, PEND, HALTED}
  - mask function op→3-bit mask
- One sub-module, flag_compute: combinational op/result/ovfl → {flags, mask}. The remainder stays in flag_unit.

Test Plan:
- Reset, then ADD with result 0x8000, ovfl = 1:
  - flags = 110 at t+1; arch_flags = 110 at t+2
  - flag_wr pulses once; wr_count = 1
- arch = 111, then XOR with result 0x0000 → arch = 111 (Z set; V, N retained). Then ROR with result 0x0001 → arch = 110.
- SUB result 0, followed immediately by ADD result 0x0005 → consecutive commits. arch = 001 then 000; flags matches each at t+1.
- ADD result 0 captured, flush asserted the next cycle:
  - arch unchanged (000); no flag_wr
  - flags returns to 000 after the flush edge
- Capture ADD, then hold stall 3 cycles → pend, arch and flag_wr frozen. Commit on the first un-stalled edge.
- After 256 commits, wr_count = 255. Then a halt with a pending SUB: it commits, and a later ADD is ignored. Async rst_n mid-pending clears all outputs to 0.
